// File: rtl/rf_pkg.sv
// Shared register-file write types and widths.
// Used by the writeback stage, the long-latency FIFO and the write-port arbiter.
package rf_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_REGS  = 32;

    // One register-file write: enable, destination, data.
    typedef struct packed {
        logic                 en;
        logic [REG_IDX_W-1:0] index;
        logic [DATA_W-1:0]    data;
    } rf_wr_t;

    // One buffered long-latency result.
    typedef struct packed {
        logic [REG_IDX_W-1:0] index;
        logic [DATA_W-1:0]    data;
    } ll_entry_t;

    // Owner of the write port in the current cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_LL   = 2'd2
    } grant_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback, long-latency, issue, hazard and RF write signals.
//   master : pipeline side (drives WB_*, LL_VALID/INDEX/DATA, ISSUE_*)
//   slave  : arbiter side (drives LL_READY, STALL_WB, BUSY_MASK, WRITE_*_RF)
interface rf_write_arbiter_if
    import rf_pkg::*;
();

    logic                 WB_EN;
    logic [REG_IDX_W-1:0] WB_INDEX;
    logic [DATA_W-1:0]    WB_DATA;
    logic                 LL_VALID;
    logic [REG_IDX_W-1:0] LL_INDEX;
    logic [DATA_W-1:0]    LL_DATA;
    logic                 LL_READY;
    logic                 ISSUE_EN;
    logic [REG_IDX_W-1:0] ISSUE_INDEX;
    logic                 STALL_WB;
    logic [NUM_REGS-1:0]  BUSY_MASK;
    logic                 WRITE_EN_RF;
    logic [REG_IDX_W-1:0] WRITE_INDEX_RF;
    logic [DATA_W-1:0]    WRITE_DATA_RF;

    modport master (
        output WB_EN, WB_INDEX, WB_DATA,
        output LL_VALID, LL_INDEX, LL_DATA,
        output ISSUE_EN, ISSUE_INDEX,
        input  LL_READY, STALL_WB, BUSY_MASK,
        input  WRITE_EN_RF, WRITE_INDEX_RF, WRITE_DATA_RF
    );

    modport slave (
        input  WB_EN, WB_INDEX, WB_DATA,
        input  LL_VALID, LL_INDEX, LL_DATA,
        input  ISSUE_EN, ISSUE_INDEX,
        output LL_READY, STALL_WB, BUSY_MASK,
        output WRITE_EN_RF, WRITE_INDEX_RF, WRITE_DATA_RF
    );

endinterface

// File: rtl/rf_ll_fifo.sv
// Long-latency result FIFO, DEPTH entries (power of two, >= 2).
//   push/push_index/push_data : write an entry (ignored when full)
//   pop                       : drop the head entry (ignored when empty)
//   full/empty                : derived from the registered occupancy only
//   head_index/head_data      : current head entry
module rf_ll_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [REG_IDX_W-1:0] push_index,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [REG_IDX_W-1:0] head_index,
    output logic [DATA_W-1:0]    head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ll_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_index = mem[rd_ptr].index;
    assign head_data  = mem[rd_ptr].data;

    // Storage, pointers (wrap naturally at DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{index: push_index, data: push_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Merges in-order writeback results with buffered long-latency results,
// stalls writeback after the FIFO head has lost STARVE_MAX arbitrations in a
// row, and tracks registers with outstanding long-latency results.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of rf_write_arbiter_if (WB, LL, issue, RF write)
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_write_arbiter_if.slave  bus
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [REG_IDX_W-1:0] head_index;
    logic [DATA_W-1:0]    head_data;

    grant_e               grant_c;
    logic                 stall_q, stall_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    rf_wr_t               wr_q, wr_d;

    assign fifo_push = bus.LL_VALID && !fifo_full;
    assign fifo_pop  = (grant_c == GRANT_LL);

    rf_ll_fifo #(
        .DEPTH (DEPTH)
    ) u_ll_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_index (bus.LL_INDEX),
        .push_data  (bus.LL_DATA),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_index (head_index),
        .head_data  (head_data)
    );

    // Grant: a stall cycle belongs to the FIFO (or nobody), else WB has priority.
    always_comb begin
        grant_c = GRANT_NONE;
        if (stall_q) begin
            if (!fifo_empty) begin
                grant_c = GRANT_LL;
            end
        end else if (bus.WB_EN) begin
            grant_c = GRANT_WB;
        end else if (!fifo_empty) begin
            grant_c = GRANT_LL;
        end
    end

    // Next state: RF write register, starvation counter/stall, scoreboard.
    always_comb begin
        wr_d     = wr_q;
        wr_d.en  = 1'b0;
        stall_d  = 1'b0;
        starve_d = starve_q;
        busy_d   = busy_q;

        case (grant_c)
            GRANT_LL: wr_d = '{en: 1'b1, index: head_index, data: head_data};
            GRANT_WB: wr_d = '{en: 1'b1, index: bus.WB_INDEX, data: bus.WB_DATA};
            default:  ;
        endcase

        // The stall is raised on the same edge the counter hits the limit.
        if (fifo_empty || grant_c == GRANT_LL) begin
            starve_d = '0;
        end else if (grant_c == GRANT_WB) begin
            if (starve_q == STARVE_W'(STARVE_MAX - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end

        // Clear first so a same-index issue in this cycle wins.
        if (grant_c == GRANT_LL) begin
            busy_d[head_index] = 1'b0;
        end
        if (bus.ISSUE_EN) begin
            busy_d[bus.ISSUE_INDEX] = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_q     <= wr_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.LL_READY       = !fifo_full;
    assign bus.STALL_WB       = stall_q;
    assign bus.BUSY_MASK      = busy_q;
    assign bus.WRITE_EN_RF    = wr_q.en;
    assign bus.WRITE_INDEX_RF = wr_q.index;
    assign bus.WRITE_DATA_RF  = wr_q.data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_write_arbiter;

    logic clk;
    logic rst_n;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_idx;
        logic [15:0] wb_data;
        logic        ll_valid;
        logic [4:0]  ll_idx;
        logic [15:0] ll_data;
        logic        iss_en;
        logic [4:0]  iss_idx;
        logic        we;
        logic [4:0]  widx;
        logic [15:0] wdata;
        logic        rdy;
        logic        stall;
        logic [31:0] busy;
    } vec_t;

    typedef struct {
        int          id;
        logic        we;
        logic [4:0]  widx;
        logic [15:0] wdata;
        logic        rdy;
        logic        stall;
        logic [31:0] busy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic wb_en, input logic [4:0] wb_idx, input logic [15:0] wb_data,
        input logic ll_valid, input logic [4:0] ll_idx, input logic [15:0] ll_data,
        input logic iss_en, input logic [4:0] iss_idx,
        input logic we, input logic [4:0] widx, input logic [15:0] wdata,
        input logic rdy, input logic stall, input logic [31:0] busy);
        vec_t v;
        v.wb_en = wb_en;   v.wb_idx = wb_idx; v.wb_data = wb_data;
        v.ll_valid = ll_valid; v.ll_idx = ll_idx; v.ll_data = ll_data;
        v.iss_en = iss_en; v.iss_idx = iss_idx;
        v.we = we; v.widx = widx; v.wdata = wdata;
        v.rdy = rdy; v.stall = stall; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.WB_EN       = v.wb_en;
        bus.WB_INDEX    = v.wb_idx;
        bus.WB_DATA     = v.wb_data;
        bus.LL_VALID    = v.ll_valid;
        bus.LL_INDEX    = v.ll_idx;
        bus.LL_DATA     = v.ll_data;
        bus.ISSUE_EN    = v.iss_en;
        bus.ISSUE_INDEX = v.iss_idx;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, " we"},    32'(bus.WRITE_EN_RF),    32'(e.we));
        chk({tag, " idx"},   32'(bus.WRITE_INDEX_RF), 32'(e.widx));
        chk({tag, " data"},  32'(bus.WRITE_DATA_RF),  32'(e.wdata));
        chk({tag, " ready"}, 32'(bus.LL_READY),       32'(e.rdy));
        chk({tag, " stall"}, 32'(bus.STALL_WB),       32'(e.stall));
        chk({tag, " busy"},  bus.BUSY_MASK,           e.busy);
    endtask

    // Drive one vector, queue its expectation, compare after the clock edge.
    task automatic apply(input int id, input vec_t v);
        exp_t e;
        drive(v);
        e.id = id; e.we = v.we; e.widx = v.widx; e.wdata = v.wdata;
        e.rdy = v.rdy; e.stall = v.stall; e.busy = v.busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard v%0d: got empty queue expected one entry", id);
        end else begin
            e = exp_q.pop_front();
            check_outputs($sformatf("v%0d", e.id), e);
        end
    endtask

    exp_t rst_exp;

    initial begin
        rst_n = 1'b0;
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0));

        // wb_en idx data | ll_valid idx data | iss idx | we idx data rdy stall busy
        // WB only, then LL only with scoreboard bit 5
        vecs.push_back(mk(1, 5'd3, 16'h1234, 0, 5'd0, 16'h0000, 0, 5'd0, 1, 5'd3,  16'h1234, 1, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 1, 5'd5, 0, 5'd3,  16'h1234, 1, 0, 32'h20));
        vecs.push_back(mk(0, 5'd0, 16'h0000, 1, 5'd5, 16'hBEEF, 0, 5'd0, 0, 5'd3,  16'h1234, 1, 0, 32'h20));
        vecs.push_back(mk(0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 0, 5'd0, 1, 5'd5,  16'hBEEF, 1, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0, 16'h0000, 0, 5'd0, 16'h0000, 0, 5'd0, 0, 5'd5,  16'hBEEF, 1, 0, 32'h0));
        // Full FIFO, held LL_VALID, starvation stall, order preserved
        vecs.push_back(mk(1, 5'd1,  16'h0101, 1, 5'd8,  16'h0808, 0, 5'd0, 1, 5'd1,  16'h0101, 1, 0, 32'h0));
        vecs.push_back(mk(1, 5'd2,  16'h0202, 1, 5'd9,  16'h0909, 0, 5'd0, 1, 5'd2,  16'h0202, 0, 0, 32'h0));
        vecs.push_back(mk(1, 5'd4,  16'h0404, 1, 5'd10, 16'h0A0A, 0, 5'd0, 1, 5'd4,  16'h0404, 0, 0, 32'h0));
        vecs.push_back(mk(1, 5'd6,  16'h0606, 1, 5'd10, 16'h0A0A, 0, 5'd0, 1, 5'd6,  16'h0606, 0, 0, 32'h0));
        vecs.push_back(mk(1, 5'd11, 16'h0B0B, 1, 5'd10, 16'h0A0A, 0, 5'd0, 1, 5'd11, 16'h0B0B, 0, 1, 32'h0));
        vecs.push_back(mk(1, 5'd12, 16'h0C0C, 1, 5'd10, 16'h0A0A, 0, 5'd0, 1, 5'd8,  16'h0808, 1, 0, 32'h0));
        vecs.push_back(mk(1, 5'd12, 16'h0C0C, 1, 5'd10, 16'h0A0A, 0, 5'd0, 1, 5'd12, 16'h0C0C, 0, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 5'd0,  16'h0000, 0, 5'd0, 1, 5'd9,  16'h0909, 1, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 5'd0,  16'h0000, 0, 5'd0, 1, 5'd10, 16'h0A0A, 1, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 5'd0,  16'h0000, 0, 5'd0, 0, 5'd10, 16'h0A0A, 1, 0, 32'h0));
        // Scoreboard collision on r7: set wins over clear
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 5'd0,  16'h0000, 1, 5'd7, 0, 5'd10, 16'h0A0A, 1, 0, 32'h80));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 1, 5'd7,  16'h7777, 0, 5'd0, 0, 5'd10, 16'h0A0A, 1, 0, 32'h80));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 5'd0,  16'h0000, 1, 5'd7, 1, 5'd7,  16'h7777, 1, 0, 32'h80));
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 5'd0,  16'h0000, 0, 5'd0, 0, 5'd7,  16'h7777, 1, 0, 32'h80));
        // Fill FIFO with two entries, BUSY_MASK=0xA0, ahead of the mid-op reset
        vecs.push_back(mk(0, 5'd0,  16'h0000, 0, 5'd0,  16'h0000, 1, 5'd5, 0, 5'd7,  16'h7777, 1, 0, 32'hA0));
        vecs.push_back(mk(1, 5'd1,  16'h1111, 1, 5'd20, 16'h2020, 0, 5'd0, 1, 5'd1,  16'h1111, 1, 0, 32'hA0));
        vecs.push_back(mk(1, 5'd2,  16'h2222, 1, 5'd21, 16'h2121, 0, 5'd0, 1, 5'd2,  16'h2222, 0, 0, 32'hA0));

        rst_exp.id = -1; rst_exp.we = 1'b0; rst_exp.widx = 5'd0; rst_exp.wdata = 16'h0;
        rst_exp.rdy = 1'b1; rst_exp.stall = 1'b0; rst_exp.busy = 32'h0;

        #12;
        check_outputs("reset", rst_exp);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply(i, vecs[i]);
        end

        // Asynchronous reset in the middle of a cycle with a full FIFO
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("midrst", rst_exp);
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 1,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("postrst1", rst_exp);
        @(posedge clk);
        #1;
        check_outputs("postrst2", rst_exp);
        apply(100, mk(1, 5'd3, 16'h3333, 0, 5'd0, 16'h0000, 0, 5'd0, 1, 5'd3, 16'h3333, 1, 0, 32'h0));

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
